// File: rtl/img_proc_pkg.sv
// Shared definitions for the image-processing pipeline front end.
//   PIX_W                 : grayscale pixel width
//   DEF_IMG_WIDTH/HEIGHT  : default frame geometry
//   feeder_state_e        : pixel_line_feeder FSM encoding
package img_proc_pkg;

    localparam int unsigned PIX_W          = 8;
    localparam int unsigned DEF_IMG_WIDTH  = 512;
    localparam int unsigned DEF_IMG_HEIGHT = 512;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREFILL  = 3'd1,
        ST_WAIT_REQ = 3'd2,
        ST_SEND     = 3'd3,
        ST_PAD      = 3'd4,
        ST_FIN      = 3'd5
    } feeder_state_e;

endpackage

// File: rtl/pixel_line_feeder_if.sv
// Bundle of the feeder's control, memory and pixel-stream signals.
//   master : the feeder (drives mem_rd_en/mem_addr, pixel_valid/pixel_input, busy, done)
//   slave  : the environment (drives start, mem_rd_data, pixel_request)
// Build option LINE_FEEDER_DROP_CNT_EN adds req_drop_cnt[7:0].
interface pixel_line_feeder_if #(
    parameter int unsigned ADDR_W = 18
);
    import img_proc_pkg::*;

    logic              start;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_rd_data;
    logic              pixel_request;
    logic              pixel_valid;
    logic [PIX_W-1:0]  pixel_input;
    logic              busy;
    logic              done;
`ifdef LINE_FEEDER_DROP_CNT_EN
    logic [7:0]        req_drop_cnt;
`endif

    modport master (
        input  start, mem_rd_data, pixel_request,
`ifdef LINE_FEEDER_DROP_CNT_EN
        output req_drop_cnt,
`endif
        output mem_rd_en, mem_addr, pixel_valid, pixel_input, busy, done
    );

    modport slave (
        output start, mem_rd_data, pixel_request,
`ifdef LINE_FEEDER_DROP_CNT_EN
        input  req_drop_cnt,
`endif
        input  mem_rd_en, mem_addr, pixel_valid, pixel_input, busy, done
    );

endinterface

// File: rtl/pixel_req_tracker.sv
// Consumer line-request tracker: registers pixel_request, detects rising
// edges and keeps a 2-bit saturating count of lines owed to the consumer.
//   clk, rst    : clock, async active-low reset
//   req_i       : raw pixel_request
//   accept_i    : edges are counted only while high
//   consume_i   : one owed line has just been delivered
//   clear_i     : zero the pending count
//   pending_o   : lines owed (0..3)
// With LINE_FEEDER_DROP_CNT_EN: start_i clears, drop_cnt_o counts edges
// lost at saturation (saturates at 255).
module pixel_req_tracker (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_i,
    input  logic       accept_i,
    input  logic       consume_i,
    input  logic       clear_i,
`ifdef LINE_FEEDER_DROP_CNT_EN
    input  logic       start_i,
    output logic [7:0] drop_cnt_o,
`endif
    output logic [1:0] pending_o
);

    logic       req_q;
    logic       req_prev_q;
    logic [1:0] pending_q;
    logic [1:0] pending_d;
    logic       count_c;
    logic       drop_c;

    // Rising edge of the registered request, gated by the accept window
    assign count_c = req_q && !req_prev_q && accept_i;
    // An edge that coincides with a consume cancels out and is never a drop
    assign drop_c  = count_c && !consume_i && (pending_q == 2'd3);

    always_comb begin
        pending_d = pending_q;
        if (clear_i) begin
            pending_d = 2'd0;
        end else if (count_c && !consume_i) begin
            if (pending_q != 2'd3) pending_d = pending_q + 2'd1;
        end else if (!count_c && consume_i && (pending_q != 2'd0)) begin
            pending_d = pending_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q      <= 1'b0;
            req_prev_q <= 1'b0;
            pending_q  <= 2'd0;
        end else begin
            req_q      <= req_i;
            req_prev_q <= req_q;
            pending_q  <= pending_d;
        end
    end

    assign pending_o = pending_q;

`ifdef LINE_FEEDER_DROP_CNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q <= 8'd0;
        end else if (start_i) begin
            drop_q <= 8'd0;
        end else if (drop_c && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_cnt_o = drop_q;
`else
    logic unused_drop;
    assign unused_drop = drop_c;
`endif

endmodule

// File: rtl/pixel_line_feeder.sv
// Streams an 8-bit frame from a 1-cycle-latency read memory to the
// consumer line by line: PREFILL_LINES lines after start, then one line per
// request edge, then PAD_LINES all-zero lines, then a done pulse.
//   clk, rst : clock, async active-low reset
//   bus      : pixel_line_feeder_if.master (start, memory port, pixel
//              stream, pixel_request, busy, done)
// Build option LINE_FEEDER_DROP_CNT_EN exposes bus.req_drop_cnt.
module pixel_line_feeder
    import img_proc_pkg::*;
#(
    parameter int unsigned IMG_WIDTH     = DEF_IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT    = DEF_IMG_HEIGHT,
    parameter int unsigned PREFILL_LINES = 4,
    parameter int unsigned PAD_LINES     = 2,
    parameter int unsigned ADDR_W        = 18
) (
    input  logic                clk,
    input  logic                rst,
    pixel_line_feeder_if.master bus
);

    localparam int unsigned PREFILL_BEATS = PREFILL_LINES * IMG_WIDTH;
    localparam int unsigned LAST_ADDR     = IMG_WIDTH * IMG_HEIGHT - 1;
    localparam int unsigned BEAT_W        = $clog2(PREFILL_BEATS) + 1;
    localparam int unsigned LINE_W        = $clog2(IMG_HEIGHT) + 1;
    localparam int unsigned PAD_W         = $clog2(PAD_LINES) + 1;

    feeder_state_e     state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [LINE_W-1:0] lines_q, lines_d;
    logic [PAD_W-1:0]  pads_q, pads_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_en_q, rd_en_d;
    logic              pad_q, pad_d;
    logic              data_sel_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;
    logic              consume_c;
    logic              accept_c;
    logic              clear_c;
    logic [1:0]        pending;

    assign accept_c = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign clear_c  = (state_q == ST_IDLE);

    pixel_req_tracker u_req_tracker (
        .clk       (clk),
        .rst       (rst),
        .req_i     (bus.pixel_request),
        .accept_i  (accept_c),
        .consume_i (consume_c),
        .clear_i   (clear_c),
`ifdef LINE_FEEDER_DROP_CNT_EN
        .start_i   ((state_q == ST_IDLE) && bus.start),
        .drop_cnt_o(bus.req_drop_cnt),
`endif
        .pending_o (pending)
    );

    // Next state, counters and read/pad strobes
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        lines_d   = lines_q;
        pads_d    = pads_q;
        addr_d    = addr_q;
        rd_en_d   = 1'b0;
        pad_d     = 1'b0;
        consume_c = 1'b0;

        // Advance after each issued read, holding at the last pixel
        if (rd_en_q && (addr_q != ADDR_W'(LAST_ADDR))) addr_d = addr_q + ADDR_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_PREFILL;
                    addr_d  = '0;
                    lines_d = '0;
                    pads_d  = '0;
                    beat_d  = '0;
                end
            end
            ST_PREFILL: begin
                rd_en_d = 1'b1;
                if (beat_q == BEAT_W'(PREFILL_BEATS - 1)) begin
                    beat_d  = '0;
                    lines_d = LINE_W'(PREFILL_LINES);
                    state_d = ST_WAIT_REQ;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            ST_WAIT_REQ: begin
                if ((lines_q == LINE_W'(IMG_HEIGHT)) && (pads_q == PAD_W'(PAD_LINES))) begin
                    state_d = ST_FIN;
                end else if (pending != 2'd0) begin
                    state_d = (lines_q != LINE_W'(IMG_HEIGHT)) ? ST_SEND : ST_PAD;
                end
            end
            ST_SEND: begin
                rd_en_d = 1'b1;
                if (beat_q == BEAT_W'(IMG_WIDTH - 1)) begin
                    beat_d    = '0;
                    consume_c = 1'b1;
                    lines_d   = lines_q + LINE_W'(1);
                    state_d   = ST_WAIT_REQ;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            ST_PAD: begin
                pad_d = 1'b1;
                if (beat_q == BEAT_W'(IMG_WIDTH - 1)) begin
                    beat_d    = '0;
                    consume_c = 1'b1;
                    pads_d    = pads_q + PAD_W'(1);
                    state_d   = ST_WAIT_REQ;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            lines_q    <= '0;
            pads_q     <= '0;
            addr_q     <= '0;
            rd_en_q    <= 1'b0;
            pad_q      <= 1'b0;
            data_sel_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            lines_q    <= lines_d;
            pads_q     <= pads_d;
            addr_q     <= addr_d;
            rd_en_q    <= rd_en_d;
            pad_q      <= pad_d;
            data_sel_q <= rd_en_q;
            valid_q    <= rd_en_q || pad_q;
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_q == ST_FIN);
        end
    end

    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_addr    = addr_q;
    assign bus.pixel_valid = valid_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    // Read data lands in the beat cycle itself, so it is gated straight through;
    // pad beats and idle cycles present zero
    assign bus.pixel_input = data_sel_q ? bus.mem_rd_data : '0;

endmodule

// File: tb/tb_pixel_line_feeder.sv
// Directed bench for pixel_line_feeder on an 8x6 frame whose memory holds
// data = address[7:0]. Scenario table plus hand-written reset, gap and
// mid-line-reset sequences. Honors LINE_FEEDER_DROP_CNT_EN.
module tb_pixel_line_feeder;
    import img_proc_pkg::*;

    localparam int unsigned W    = 8;
    localparam int unsigned H    = 6;
    localparam int unsigned PF   = 4;
    localparam int unsigned PADL = 2;
    localparam int unsigned AW   = 18;
    localparam int          IMG_BEATS = W * H;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pixel_line_feeder_if #(.ADDR_W(AW)) bus ();

    pixel_line_feeder #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .PREFILL_LINES(PF), .PAD_LINES(PADL), .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Synchronous read memory, contents = address[7:0]
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= bus.mem_addr[7:0];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    int idle_nz = 0;
    bit mon_en = 1'b0;
    int beat_val[$];
    int beat_cyc[$];

    // Beat recorder, sampled away from the active edge
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.pixel_valid) begin
                beat_val.push_back(int'(bus.pixel_input));
                beat_cyc.push_back(cyc);
            end else if (bus.pixel_input != 8'd0) begin
                idle_nz++;
            end
            if (bus.done) done_cnt++;
        end
    end

    typedef struct {
        string name;
        int    n_req;
        int    req_at;
        int    req_gap;
        int    busy_start;
        int    ncyc;
        int    exp_beats;
        int    exp_done;
        int    exp_busy;
        int    exp_drop;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.start = 1'b0;
        bus.pixel_request = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Start at relative cycle 0; request k is high for 2 cycles at req_at+k*req_gap
    task automatic run_frame(input int n_req, input int req_at, input int req_gap,
                             input int busy_start, input int ncyc);
        beat_val.delete();
        beat_cyc.delete();
        done_cnt = 0;
        idle_nz  = 0;
        mon_en   = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            if (c == 1) start_cyc = cyc;
            bus.start = (c == 0) ||
                        ((busy_start > 0) && ((c == busy_start) || (c == busy_start + 40)));
            bus.pixel_request = 1'b0;
            for (int k = 0; k < n_req; k++) begin
                if ((c >= req_at + k * req_gap) && (c < req_at + k * req_gap + 2))
                    bus.pixel_request = 1'b1;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.pixel_request = 1'b0;
        mon_en = 1'b0;
    endtask

    function automatic int first_bad();
        for (int i = 0; i < beat_val.size(); i++) begin
            if (beat_val[i] != ((i < IMG_BEATS) ? (i % 256) : 0)) return i;
        end
        return -1;
    endfunction

    function automatic int gap(input int i);
        if (i < 1 || i >= beat_cyc.size()) return -1;
        return beat_cyc[i] - beat_cyc[i-1];
    endfunction

    function automatic int latency();
        if (beat_cyc.size() == 0) return -1;
        return beat_cyc[0] - start_cyc;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_en"}, 32'(bus.mem_rd_en), 0);
        check({tag, "_addr"},  32'(bus.mem_addr), 0);
        check({tag, "_valid"}, 32'(bus.pixel_valid), 0);
        check({tag, "_pixel"}, 32'(bus.pixel_input), 0);
        check({tag, "_busy"},  32'(bus.busy), 0);
        check({tag, "_done"},  32'(bus.done), 0);
    endtask

    initial begin
        bit hit;
        vecs[0] = '{"noreq",         0,  0,  0,  0,  60, 32, 0, 1, 0};
        vecs[1] = '{"four_after",    4, 40, 20,  0, 140, 64, 1, 0, 0};
        vecs[2] = '{"three_prefill", 3,  4,  4,  0,  90, 56, 0, 1, 0};
        vecs[3] = '{"five_prefill",  5,  4,  4,  0,  90, 56, 0, 1, 2};
        vecs[4] = '{"start_busy",    4, 40, 20, 10, 140, 64, 1, 0, 0};
        vecs[5] = '{"late_req",      5, 40, 20,  0, 160, 64, 1, 0, 0};

        bus.start = 1'b0;
        bus.pixel_request = 1'b0;
        #12;
        check_outputs_zero("in_reset");
        do_reset();

        for (int v = 0; v < 6; v++) begin
            do_reset();
            run_frame(vecs[v].n_req, vecs[v].req_at, vecs[v].req_gap,
                      vecs[v].busy_start, vecs[v].ncyc);
            check({vecs[v].name, "_beats"},   32'(beat_val.size()), 32'(vecs[v].exp_beats));
            check({vecs[v].name, "_badbeat"}, 32'(first_bad()), 32'(-1));
            check({vecs[v].name, "_latency"}, 32'(latency()), 2);
            check({vecs[v].name, "_done"},    32'(done_cnt), 32'(vecs[v].exp_done));
            check({vecs[v].name, "_busy"},    32'(bus.busy), 32'(vecs[v].exp_busy));
            check({vecs[v].name, "_idle_px"}, 32'(idle_nz), 0);
`ifdef LINE_FEEDER_DROP_CNT_EN
            check({vecs[v].name, "_drops"},   32'(bus.req_drop_cnt), 32'(vecs[v].exp_drop));
`endif
        end

        // Requests queued during prefill: one valid-low cycle between lines
        do_reset();
        run_frame(3, 4, 4, 0, 90);
        check("gap_prefill_line4", 32'(gap(32)), 2);
        check("gap_in_line4",      32'(gap(33)), 1);
        check("gap_line4_line5",   32'(gap(40)), 2);
        check("gap_line5_pad1",    32'(gap(48)), 2);

        // Reset at beat 3 of line 4, then a clean restart
        do_reset();
        hit = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (bus.pixel_valid && (bus.pixel_input == 8'd35)) begin
                hit = 1'b1;
                break;
            end
            bus.start = (c == 0);
            bus.pixel_request = (c >= 4) && (c < 6);
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.pixel_request = 1'b0;
        check("midrst_reached_beat", 32'(hit), 1);
        rst = 1'b0;
        #1;
        check_outputs_zero("midrst");
        @(negedge clk);
        @(negedge clk);
        check("midrst_held_valid", 32'(bus.pixel_valid), 0);
        rst = 1'b1;
        @(negedge clk);
        run_frame(0, 0, 0, 0, 60);
        check("restart_beats",   32'(beat_val.size()), 32);
        check("restart_badbeat", 32'(first_bad()), 32'(-1));
        check("restart_latency", 32'(latency()), 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
